// File: rtl/aer_event_fifo_pkg.sv
// rtl/aer_event_fifo_pkg.sv - shared AER event width and FIFO sizing defaults
package aer_event_fifo_pkg;

  // Defaults shared by the AER encoder, arbiter and event FIFO
  localparam int AER_VECTOR_WIDTH  = 5;
  localparam int AER_ADDR_WIDTH    = 4;
  localparam int AER_DROP_W        = 16;
  localparam int AER_AFULL_THRESH  = 12;
  localparam int AER_AEMPTY_THRESH = 2;

endpackage

// File: rtl/aer_fifo_mem.sv
// rtl/aer_fifo_mem.sv - event storage array, synchronous write, asynchronous read
module aer_fifo_mem
  import aer_event_fifo_pkg::*;
#(
  parameter int WIDTH      = AER_VECTOR_WIDTH,
  parameter int ADDR_WIDTH = AER_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  // Contents are not reset; validity is tracked by the FIFO occupancy count
  logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Store an accepted event at the write pointer
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/aer_event_fifo.sv
// rtl/aer_event_fifo.sv - AER spike-event FIFO with watermarks and drop accounting
module aer_event_fifo
  import aer_event_fifo_pkg::*;
#(
  parameter int VECTOR_WIDTH  = AER_VECTOR_WIDTH,
  parameter int ADDR_WIDTH    = AER_ADDR_WIDTH,
  parameter int AFULL_THRESH  = AER_AFULL_THRESH,
  parameter int AEMPTY_THRESH = AER_AEMPTY_THRESH,
  parameter int FWFT          = 1,
  parameter int DROP_W        = AER_DROP_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VECTOR_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [VECTOR_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LP_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] LP_AFULL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] LP_AEMPTY = CW'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [DROP_W-1:0]       r_drop_count;
  logic                    r_overflow;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_rd_adv;
  logic                    w_out_valid;
  logic [VECTOR_WIDTH-1:0] w_mem_rdata;

  // Full/empty come from the registered count only, so in_ready never sees out_ready
  assign in_ready     = (r_count < LP_DEPTH);
  assign w_push       = in_valid && in_ready;
  assign w_drop       = in_valid && !in_ready;
  assign w_pop        = w_out_valid && out_ready;
  assign out_valid    = w_out_valid;
  assign count        = r_count;
  assign almost_full  = (r_count >= LP_AFULL);
  assign almost_empty = (r_count <= LP_AEMPTY);
  assign overflow     = r_overflow;
  assign drop_count   = r_drop_count;

  aer_fifo_mem #(
    .WIDTH      (VECTOR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  // Pointers wrap modulo DEPTH; count covers memory plus any output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Events offered while full are discarded and counted, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + DROP_W'(1);
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of memory is presented directly; a pop advances the read pointer
      assign w_out_valid = (r_count != '0);
      assign out_data    = w_mem_rdata;
      assign w_rd_adv    = w_pop;
    end else begin : g_reg_out
      logic                    r_out_valid;
      logic [VECTOR_WIDTH-1:0] r_out_data;
      logic [CW-1:0]           w_mem_count;
      logic                    w_load;

      // The output register holds one of the DEPTH entries, so memory holds the rest
      assign w_mem_count = r_count - CW'(r_out_valid);
      assign w_load      = (!r_out_valid || w_pop) && (w_mem_count != '0);
      assign w_rd_adv    = w_load;
      assign w_out_valid = r_out_valid;
      assign out_data    = r_out_data;

      // Refill the output register when it is empty or being consumed
      always_ff @(posedge clk) begin
        if (reset) begin
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
        end else if (w_load) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_mem_rdata;
        end else if (w_pop) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_aer_event_fifo.sv
// tb/tb_aer_event_fifo.sv - self-checking bench for both output modes of aer_event_fifo
module tb_aer_event_fifo;

  localparam int VW    = 5;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] in_data;
  logic          in_valid;
  logic          out_ready;

  // Index 0: FWFT=1 instance, index 1: FWFT=0 instance
  logic          in_ready     [2];
  logic [VW-1:0] out_data     [2];
  logic          out_valid    [2];
  logic [AW:0]   count        [2];
  logic          almost_full  [2];
  logic          almost_empty [2];
  logic          overflow     [2];
  logic [DW-1:0] drop_count   [2];

  int n_vec = 0;
  int n_err = 0;

  int            m_cnt  [2];
  bit            m_ov   [2];
  int            m_drop [2];
  bit            m_ovf  [2];
  logic [VW-1:0] sb     [2][$];

  typedef struct {
    logic          iv;
    logic [VW-1:0] data;
    int            e_count;
    logic          e_af;
    logic          e_ae;
    logic          e_rdy;
    int            e_drop;
  } vec_t;

  vec_t tbl [19];

  always #5 clk = ~clk;

  aer_event_fifo #(.FWFT(1)) u_fwft (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready[0]),
    .out_data     (out_data[0]),
    .out_valid    (out_valid[0]),
    .out_ready    (out_ready),
    .count        (count[0]),
    .almost_full  (almost_full[0]),
    .almost_empty (almost_empty[0]),
    .overflow     (overflow[0]),
    .drop_count   (drop_count[0])
  );

  aer_event_fifo #(.FWFT(0)) u_reg (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready[1]),
    .out_data     (out_data[1]),
    .out_valid    (out_valid[1]),
    .out_ready    (out_ready),
    .count        (count[1]),
    .almost_full  (almost_full[1]),
    .almost_empty (almost_empty[1]),
    .overflow     (overflow[1]),
    .drop_count   (drop_count[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic string mn(input int d);
    return (d == 0) ? "fwft1" : "fwft0";
  endfunction

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      logic ev;
      ev = (d == 0) ? (m_cnt[d] != 0) : m_ov[d];
      chk({"count_", mn(d)}, 32'(count[d]), m_cnt[d]);
      chk({"in_ready_", mn(d)}, 32'(in_ready[d]), 32'(m_cnt[d] < DEPTH));
      chk({"almost_full_", mn(d)}, 32'(almost_full[d]), 32'(m_cnt[d] >= 12));
      chk({"almost_empty_", mn(d)}, 32'(almost_empty[d]), 32'(m_cnt[d] <= 2));
      chk({"out_valid_", mn(d)}, 32'(out_valid[d]), 32'(ev));
      chk({"overflow_", mn(d)}, 32'(overflow[d]), 32'(m_ovf[d]));
      chk({"drop_count_", mn(d)}, 32'(drop_count[d]), m_drop[d]);
      if (ev && sb[d].size() > 0) begin
        chk({"out_data_", mn(d)}, 32'(out_data[d]), 32'(sb[d][0]));
      end
    end
  endtask

  // Check current outputs, advance the model across the coming edge, then step past it
  task automatic tick();
    check_model();
    for (int d = 0; d < 2; d++) begin
      bit rdy, push, drop, pop, load;
      int memcnt;
      if (reset) begin
        m_cnt[d]  = 0;
        m_ov[d]   = 1'b0;
        m_drop[d] = 0;
        m_ovf[d]  = 1'b0;
        sb[d].delete();
      end else begin
        rdy  = (m_cnt[d] < DEPTH);
        push = in_valid && rdy;
        drop = in_valid && !rdy;
        if (d == 0) begin
          pop = (m_cnt[d] != 0) && out_ready;
        end else begin
          pop    = m_ov[d] && out_ready;
          memcnt = m_cnt[d] - int'(m_ov[d]);
          load   = (!m_ov[d] || pop) && (memcnt != 0);
          m_ov[d] = load ? 1'b1 : (pop ? 1'b0 : m_ov[d]);
        end
        if (pop) void'(sb[d].pop_front());
        if (push) sb[d].push_back(in_data);
        m_cnt[d] = m_cnt[d] + int'(push) - int'(pop);
        if (drop) begin
          m_ovf[d] = 1'b1;
          if (m_drop[d] != 65535) m_drop[d]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_ov[d] = 1'b0; m_drop[d] = 0; m_ovf[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill 1..16 with the consumer stalled, then offer 31 three times while full
    for (int i = 0; i < 19; i++) begin
      tbl[i].iv      = 1'b1;
      tbl[i].data    = (i < 16) ? VW'(i + 1) : 5'd31;
      tbl[i].e_count = (i < 16) ? i + 1 : 16;
      tbl[i].e_af    = (tbl[i].e_count >= 12);
      tbl[i].e_ae    = (tbl[i].e_count <= 2);
      tbl[i].e_rdy   = (tbl[i].e_count < 16);
      tbl[i].e_drop  = (i < 16) ? 0 : i - 15;
    end
    for (int i = 0; i < 19; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].data;
      out_ready = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("tbl%0d_count_%s", i, mn(d)), 32'(count[d]), tbl[i].e_count);
        chk($sformatf("tbl%0d_af_%s", i, mn(d)), 32'(almost_full[d]), 32'(tbl[i].e_af));
        chk($sformatf("tbl%0d_ae_%s", i, mn(d)), 32'(almost_empty[d]), 32'(tbl[i].e_ae));
        chk($sformatf("tbl%0d_rdy_%s", i, mn(d)), 32'(in_ready[d]), 32'(tbl[i].e_rdy));
        chk($sformatf("tbl%0d_drop_%s", i, mn(d)), 32'(drop_count[d]), tbl[i].e_drop);
        chk($sformatf("tbl%0d_ovf_%s", i, mn(d)), 32'(overflow[d]), 32'(tbl[i].e_drop != 0));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    for (int d = 0; d < 2; d++) chk({"drained_", mn(d)}, 32'(count[d]), 0);

    // Steady push+pop at depth 8; pointers wrap several times
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = VW'($urandom);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = VW'(i);
      tick();
      for (int d = 0; d < 2; d++) chk($sformatf("steady%0d_%s", i, mn(d)), 32'(count[d]), 8);
    end
    in_valid = 1'b0;
    repeat (12) tick();

    // Single event into an empty FIFO: latency 1 (FWFT) vs 2 (registered)
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h0A;
    tick();
    in_valid = 1'b0;
    chk("lat1_valid_fwft1", 32'(out_valid[0]), 1);
    chk("lat1_data_fwft1", 32'(out_data[0]), 32'h0A);
    chk("lat1_valid_fwft0", 32'(out_valid[1]), 0);
    tick();
    chk("lat2_valid_fwft0", 32'(out_valid[1]), 1);
    chk("lat2_data_fwft0", 32'(out_data[1]), 32'h0A);

    // Stalled head stays put, then drains one per cycle
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = VW'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("stall%0d_data_%s", i, mn(d)), 32'(out_data[d]), 32'h0A);
        chk($sformatf("stall%0d_valid_%s", i, mn(d)), 32'(out_valid[d]), 1);
      end
    end
    out_ready = 1'b1;
    repeat (6) tick();

    // Random traffic checked against the scoreboard
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 1) == 1);
      in_data   = VW'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();

    // Reset mid-burst at count 7 with a push pending
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = VW'(i + 20);
      tick();
    end
    for (int d = 0; d < 2; d++) chk({"pre_reset_count_", mn(d)}, 32'(count[d]), 7);
    reset    = 1'b1;
    in_valid = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk({"rst_count_", mn(d)}, 32'(count[d]), 0);
      chk({"rst_valid_", mn(d)}, 32'(out_valid[d]), 0);
      chk({"rst_ready_", mn(d)}, 32'(in_ready[d]), 1);
      chk({"rst_drop_", mn(d)}, 32'(drop_count[d]), 0);
      chk({"rst_ovf_", mn(d)}, 32'(overflow[d]), 0);
      chk({"rst_af_", mn(d)}, 32'(almost_full[d]), 0);
      chk({"rst_ae_", mn(d)}, 32'(almost_empty[d]), 1);
    end
    chk("rst_outreg_fwft0", 32'(out_data[1]), 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
